// File: rtl/rd_resp_router.sv
// Master-side read response router: remembers which slave port issued each
// accepted read and steers the master's responses back in request order.
module rd_resp_router #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     rd_req,
    input  logic                     slave_id,
    input  logic                     resp,
    input  logic [DATA_WIDTH-1:0]    rdata,
    output logic                     s0_resp,
    output logic                     s1_resp,
    output logic [DATA_WIDTH-1:0]    s_rdata,
    output logic                     rd_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_overflow,
    output logic                     err_orphan
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             head;
    logic             pop;
    logic             push;

    assign rd_full = (count == CNT_W'(DEPTH));
    assign head    = fifo_mem[rd_ptr];
    // A response never pairs with a read acked in the same cycle, so an
    // empty FIFO drops the beat even if a push lands alongside it.
    assign pop     = resp && (count != '0);
    assign push    = rd_req && (!rd_full || pop);

    // NOTE: the ordering storage carries no reset; the count and pointers
    // alone decide which entries are valid, so stale contents are harmless.
    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= slave_id;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so that a
    // full-FIFO push+pop reads the old head before the slot is rewritten.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            s0_resp      <= 1'b0;
            s1_resp      <= 1'b0;
            s_rdata      <= '0;
            err_overflow <= 1'b0;
            err_orphan   <= 1'b0;
        end else begin
            s0_resp <= pop && !head;
            s1_resp <= pop && head;
            if (pop) begin
                s_rdata <= rdata;
                rd_ptr  <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (rd_req && rd_full && !pop) begin
                err_overflow <= 1'b1;
            end
            if (resp && !pop) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rd_resp_router.sv
// Self-checking bench for rd_resp_router: directed vector table plus
// hand-written wrap-around and mid-operation reset sequences.
module tb_rd_resp_router;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          rd_req;
    logic          slave_id;
    logic          resp;
    logic [DW-1:0] rdata;
    logic          s0_resp;
    logic          s1_resp;
    logic [DW-1:0] s_rdata;
    logic          rd_full;
    logic [3:0]    count;
    logic          err_overflow;
    logic          err_orphan;

    int n_cmp = 0;
    int n_bad = 0;

    rd_resp_router #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .rd_req      (rd_req),
        .slave_id    (slave_id),
        .resp        (resp),
        .rdata       (rdata),
        .s0_resp     (s0_resp),
        .s1_resp     (s1_resp),
        .s_rdata     (s_rdata),
        .rd_full     (rd_full),
        .count       (count),
        .err_overflow(err_overflow),
        .err_orphan  (err_orphan)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic          rd_req;
        logic          id;
        logic          resp;
        logic [DW-1:0] rdata;
        logic          e_s0;
        logic          e_s1;
        logic [DW-1:0] e_data;
        logic [3:0]    e_cnt;
        logic          e_full;
        logic          e_ov;
        logic          e_or;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic v(input logic req, input logic id, input logic rs, input logic [DW-1:0] d,
                     input logic s0, input logic s1, input logic [DW-1:0] ed,
                     input logic [3:0] cnt, input logic full, input logic ov, input logic orp);
        vec_t t;
        t = '{req, id, rs, d, s0, s1, ed, cnt, full, ov, orp};
        vecs.push_back(t);
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic req, input logic id, input logic rs, input logic [DW-1:0] d);
        rd_req   = req;
        slave_id = id;
        resp     = rs;
        rdata    = d;
        @(posedge aclk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic s0, input logic s1,
                             input logic [DW-1:0] ed, input logic [3:0] cnt,
                             input logic full, input logic ov, input logic orp);
        check({tag, " s0_resp"},      DW'(s0_resp),      DW'(s0));
        check({tag, " s1_resp"},      DW'(s1_resp),      DW'(s1));
        check({tag, " s_rdata"},      s_rdata,           ed);
        check({tag, " count"},        DW'(count),        DW'(cnt));
        check({tag, " rd_full"},      DW'(rd_full),      DW'(full));
        check({tag, " err_overflow"}, DW'(err_overflow), DW'(ov));
        check({tag, " err_orphan"},   DW'(err_orphan),   DW'(orp));
    endtask

    initial begin
        logic prev_id;
        logic cur_id;

        // Single read
        v(1, 1, 0, 0,            0, 0, 0,            1, 0, 0, 0);
        v(0, 0, 1, 32'hA5A50001, 0, 1, 32'hA5A50001, 0, 0, 0, 0);
        v(0, 0, 0, 0,            0, 0, 32'hA5A50001, 0, 0, 0, 0);
        // Interleaved order 0,1,1,0
        v(1, 0, 0, 0, 0, 0, 32'hA5A50001, 1, 0, 0, 0);
        v(1, 1, 0, 0, 0, 0, 32'hA5A50001, 2, 0, 0, 0);
        v(1, 1, 0, 0, 0, 0, 32'hA5A50001, 3, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0, 32'hA5A50001, 4, 0, 0, 0);
        v(0, 0, 1, 1, 1, 0, 1, 3, 0, 0, 0);
        v(0, 0, 1, 2, 0, 1, 2, 2, 0, 0, 0);
        v(0, 0, 1, 3, 0, 1, 3, 1, 0, 0, 0);
        v(0, 0, 1, 4, 1, 0, 4, 0, 0, 0, 0);
        // Fill to DEPTH with ids 0,1,0,1,...
        for (int k = 0; k < DEPTH; k++) begin
            v(1, k[0], 0, 0, 0, 0, 4, 4'(k + 1), (k == DEPTH - 1), 0, 0);
        end
        // Push while full without pop: dropped, overflow flagged
        v(1, 0, 0, 0, 0, 0, 4, 8, 1, 1, 0);
        // Push while full with pop: head id 0 routed, count stays 8
        v(1, 1, 1, 32'h10, 1, 0, 32'h10, 8, 1, 1, 0);
        // Drain: ids 1,0,1,0,1,0,1 then the late-pushed 1
        for (int k = 0; k < DEPTH; k++) begin
            cur_id = (k == DEPTH - 1) ? 1'b1 : ((k % 2) == 0);
            v(0, 0, 1, DW'(32'h11 + k), !cur_id, cur_id, DW'(32'h11 + k), 4'(7 - k), 0, 1, 0);
        end
        // Orphan with same-cycle push of id 0
        v(1, 0, 1, 32'hDEAD, 0, 0, 32'h18, 1, 0, 1, 1);
        v(0, 0, 1, 32'h20,   1, 0, 32'h20, 0, 0, 1, 1);

        rd_req = 0; slave_id = 0; resp = 0; rdata = 0;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rd_req, vecs[i].id, vecs[i].resp, vecs[i].rdata);
            check_all($sformatf("vec%0d", i), vecs[i].e_s0, vecs[i].e_s1, vecs[i].e_data,
                      vecs[i].e_cnt, vecs[i].e_full, vecs[i].e_ov, vecs[i].e_or);
        end

        // Clear sticky errors before the wrap-around run
        aresetn = 1'b0;
        step(0, 0, 0, 0);
        aresetn = 1'b1;
        check_all("reset2", 0, 0, 0, 0, 0, 0, 0);

        // Wrap-around: 20 back-to-back push/pop pairs, alternating ids
        step(1, 0, 0, 0);
        prev_id = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cur_id = ((i % 2) == 0);
            step(1, cur_id, 1, DW'(32'h100 + i));
            check_all($sformatf("wrap%0d", i), !prev_id, prev_id, DW'(32'h100 + i), 1, 0, 0, 0);
            prev_id = cur_id;
        end
        step(0, 0, 1, 32'h200);
        check_all("wrap_drain", !prev_id, prev_id, 32'h200, 0, 0, 0, 0);

        // Reset mid-operation with 3 outstanding entries
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        check("pre_reset count", DW'(count), 3);
        aresetn = 1'b0;
        step(0, 0, 0, 0);
        aresetn = 1'b1;
        check_all("midreset", 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'hBEEF);
        check_all("post_reset_resp", 0, 0, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rd_resp_router.md
# rd_resp_router

Master-side read response router for the two-slave cross bar. It records, in request order, which slave port issued each read accepted by a master port. It then steers every read response from that master back to the originating slave port, one response per recorded request. One instance sits on each master port, next to the request arbiter. It is the counterpart of the slave-side read request counting that gates response acceptance.

## Interface
- DATA_WIDTH, 32, read data width.
- DEPTH, 8, ordering FIFO depth (outstanding reads); power of two, ≥ 2.
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  synchronous, active-low reset.
- rd_req  in  1  read accepted by this master this cycle (req & !cmd & ack on master port).
- slave_id  in  1  slave port granted for the accepted request (0 or 1); sampled only with rd_req.
- resp  in  1  master response strobe, one cycle per read beat.
- rdata  in  DATA_WIDTH  master read data, valid with resp.
- s0_resp  out  1  response strobe to slave port 0.
- s1_resp  out  1  response strobe to slave port 1.
- s_rdata  out  DATA_WIDTH  read data to both slave ports, qualified by s0_resp/s1_resp.
- rd_full  out  1  FIFO full; arbiter must not ack further reads while high.
- count  out  $clog2(DEPTH)+1  outstanding read count, 0..DEPTH.
- err_overflow  out  1  sticky: rd_req seen while full without a same-cycle pop.
- err_orphan  out  1  sticky: resp seen with no outstanding request.

## Operation
- FIFO of DEPTH 1-bit entries, with write pointer, read pointer and count. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push: rd_req writes slave_id at the write pointer and advances it.
- Pop: resp while count > 0 reads the head entry, routes the beat and advances the read pointer.
- Routing: head = 0 gives s0_resp = 1; head = 1 gives s1_resp = 1. s_rdata is loaded with rdata. The two strobes are never high together.
- count update: +1 on push only, −1 on pop only, unchanged on push+pop.
- rd_full is combinational: count == DEPTH.
- Full + rd_req + resp: both proceed, and the new entry takes the freed slot.
- Full + rd_req without resp: the push is dropped, err_overflow is set, and state is unchanged.
- Empty + resp, including when rd_req occurs in the same cycle: the beat is dropped, no strobe is issued and err_orphan is set. A same-cycle rd_req is still pushed. A response never belongs to the request acked in the same cycle.
- err_overflow and err_orphan clear only on reset.
- s_rdata holds its last value when no strobe is active.
- No state machine beyond the FIFO. Behaviour is fully determined by count, the pointers and the inputs.

## Timing
- Reset (aresetn low at an edge): pointers 0, count 0, s0_resp 0, s1_resp 0, s_rdata 0, err_overflow 0, err_orphan 0. rd_full reads 0 after reset.
- Reset mid-operation discards all outstanding entries. Responses arriving afterwards for those discarded entries set err_orphan.
- Routing latency: s0_resp/s1_resp and s_rdata are registered and appear 1 cycle after the resp edge.
- count, rd_full and the pointers update at the edge that samples rd_req/resp.
- Throughput: one push and one pop per cycle, sustained.
- Minimum request-to-response gap at the master is 1 cycle. A response in cycle N+1 after a push in cycle N is routed normally.

## Test plan
- Single read: rd_req with slave_id = 1, then resp with rdata = 0xA5A5_0001 one cycle later. Required: s1_resp high for 1 cycle, one cycle after resp; s_rdata = 0xA5A5_0001; s0_resp stays 0; count goes 0→1→0.
- Interleaved order: pushes with ids 0,1,1,0, then four resp beats with rdata 1..4. Required: strobes s0,s1,s1,s0 carrying data 1,2,3,4 in order; count returns to 0.
- Full boundary (DEPTH = 8): 8 pushes give rd_full = 1 and count = 8. A 9th rd_req without resp sets err_overflow = 1 and leaves count = 8. A 9th rd_req with a same-cycle resp keeps count = 8 with no error, and the new entry is routed last.
- Orphan: resp on an empty FIFO with rdata = 0xDEAD. Required: no strobe, err_orphan = 1. A same-cycle rd_req with id 0 is still pushed, so count = 1.
- Wrap-around: run 20 push/pop pairs back-to-back with alternating ids. Required: correct routing across pointer wrap and count stable at ≤ 1.
- Reset mid-operation: 3 outstanding entries, then aresetn low for 1 cycle. Required: count = 0, strobes 0, errors 0. A later resp sets err_orphan.
